lc3_regfile_sb: RTL

Parametrised successor to the LC-3 register block: a 2-read/1-write register file with a registered write-back stage, per-register pending-write scoreboard and issue-stall generation. Sits between decode (IR, ISSUE) and the ALU/memory write-back path (Y, DATA). Source fields are taken from IR at configurable bit positions. Optional read bypass from the write-back stage.

---
 rtl/lc3_regfile_sb_if.sv | 35 +++
 rtl/lc3_regfile_sb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lc3_regfile_sb_if.sv
// Decode / write-back bundle for the lc3_regfile_sb scoreboarded register file.
// master = decode + write-back source, slave = register file.
interface lc3_regfile_sb_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [WIDTH-1:0]    IR;
    logic                ISSUE;
    logic                ISSUE_WR;
    logic                USE_RS2;
    logic                WB_VALID;
    logic                WB_SEL;
    logic [ADDR_W-1:0]   WB_ADDR;
    logic [WIDTH-1:0]    Y;
    logic [WIDTH-1:0]    DATA;
    logic [WIDTH-1:0]    RS1_DATA;
    logic [WIDTH-1:0]    RS2_DATA;
    logic                RS1_BUSY;
    logic                RS2_BUSY;
    logic                STALL;
    logic [NUM_REGS-1:0] PENDING;
    logic                WB_ERR;

    modport master (
        output IR, ISSUE, ISSUE_WR, USE_RS2, WB_VALID, WB_SEL, WB_ADDR, Y, DATA,
        input  RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY, STALL, PENDING, WB_ERR
    );

    modport slave (
        input  IR, ISSUE, ISSUE_WR, USE_RS2, WB_VALID, WB_SEL, WB_ADDR, Y, DATA,
        output RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY, STALL, PENDING, WB_ERR
    );
endinterface

// File: rtl/lc3_regfile_sb.sv
// 2R/1W register file with registered write-back stage and per-register pending-write scoreboard.
// Optional read bypass from the write-back stage: define REGFILE_BYPASS_EN.
module lc3_regfile_sb #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3,
    parameter int RD_LSB  = 9,
    parameter int RS1_LSB = 6,
    parameter int RS2_LSB = 0
) (
    input logic             CLK,
    input logic             RST,
    lc3_regfile_sb_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [WIDTH-1:0]    regs_r [NUM_REGS];
    logic [1:0]          cnt_r  [NUM_REGS];
    logic                wb_v_r;
    logic [ADDR_W-1:0]   wb_a_r;
    logic [WIDTH-1:0]    wb_d_r;
    logic                wb_err_r;

    logic [ADDR_W-1:0]   rd_s;
    logic [ADDR_W-1:0]   rs1_s;
    logic [ADDR_W-1:0]   rs2_s;
    logic [WIDTH-1:0]    rs1_data_s;
    logic [WIDTH-1:0]    rs2_data_s;
    logic                rs1_busy_s;
    logic                rs2_busy_raw_s;
    logic                rs2_busy_s;
    logic                stall_s;
    logic                accept_s;
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] pending_s;

    assign rd_s  = bus.IR[RD_LSB  +: ADDR_W];
    assign rs1_s = bus.IR[RS1_LSB +: ADDR_W];
    assign rs2_s = bus.IR[RS2_LSB +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    logic hit1_s;
    logic hit2_s;

    // A source committing this edge is served from wb_d and its last pending write counts as resolved
    assign hit1_s         = wb_v_r && (wb_a_r == rs1_s);
    assign hit2_s         = wb_v_r && (wb_a_r == rs2_s);
    assign rs1_data_s     = hit1_s ? wb_d_r : regs_r[rs1_s];
    assign rs2_data_s     = hit2_s ? wb_d_r : regs_r[rs2_s];
    assign rs1_busy_s     = (cnt_r[rs1_s] > 2'd1) || ((cnt_r[rs1_s] == 2'd1) && !hit1_s);
    assign rs2_busy_raw_s = (cnt_r[rs2_s] > 2'd1) || ((cnt_r[rs2_s] == 2'd1) && !hit2_s);
`else
    assign rs1_data_s     = regs_r[rs1_s];
    assign rs2_data_s     = regs_r[rs2_s];
    assign rs1_busy_s     = (cnt_r[rs1_s] != 2'd0);
    assign rs2_busy_raw_s = (cnt_r[rs2_s] != 2'd0);
`endif

    assign rs2_busy_s = rs2_busy_raw_s && bus.USE_RS2;
    assign stall_s    = bus.ISSUE && (rs1_busy_s || rs2_busy_s ||
                                      (bus.ISSUE_WR && (cnt_r[rd_s] == 2'd3)));
    assign accept_s   = bus.ISSUE && !stall_s && bus.ISSUE_WR;

    // Per-register increment/decrement requests and pending flags
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_s[i]     = accept_s && (rd_s == ADDR_W'(i));
            dec_s[i]     = wb_v_r && (wb_a_r == ADDR_W'(i));
            pending_s[i] = (cnt_r[i] != 2'd0);
        end
    end

    // Write-back capture stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_v_r <= 1'b0;
            wb_a_r <= '0;
            wb_d_r <= '0;
        end else begin
            wb_v_r <= bus.WB_VALID;
            wb_a_r <= bus.WB_ADDR;
            wb_d_r <= bus.WB_SEL ? bus.DATA : bus.Y;
        end
    end

    // Register array commit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_v_r) begin
            regs_r[wb_a_r] <= wb_d_r;
        end else begin
            regs_r[wb_a_r] <= regs_r[wb_a_r];
        end
    end

    // Scoreboard counts: issue and commit on the same register cancel out
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_s[i] && !dec_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + 2'd1;
                end else if (dec_s[i] && !inc_s[i] && (cnt_r[i] != 2'd0)) begin
                    cnt_r[i] <= cnt_r[i] - 2'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Sticky flag for a commit that had no matching pending write
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_err_r <= 1'b0;
        end else if (wb_v_r && (cnt_r[wb_a_r] == 2'd0)) begin
            wb_err_r <= 1'b1;
        end else begin
            wb_err_r <= wb_err_r;
        end
    end

    assign bus.RS1_DATA = rs1_data_s;
    assign bus.RS2_DATA = rs2_data_s;
    assign bus.RS1_BUSY = rs1_busy_s;
    assign bus.RS2_BUSY = rs2_busy_s;
    assign bus.STALL    = stall_s;
    assign bus.PENDING  = pending_s;
    assign bus.WB_ERR   = wb_err_r;
endmodule
